// File: rtl/note_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_input_pkg
// Description : Shared types and helpers for the note input encoder. Holds the
//               key FSM state encoding, the note-code width, the key-count
//               ceiling and the key-index-to-note-code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package note_input_pkg;

    localparam int CODE_W   = 4;
    localparam int MAX_KEYS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        CHORD = 2'd2
    } key_state_t;

    // Key i is reported to the game controller as note code i+1; code 0 is
    // reserved for "no key".
    function automatic logic [CODE_W-1:0] key_to_code(input int idx);
        return CODE_W'(idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Two-flop synchronizer plus a shared vector debounce for a bank
//               of push buttons. The whole vector must hold one value for
//               DEBOUNCE_CYCLES consecutive comparisons before it is accepted.
// Ports       : clk     - system clock
//               reset   - asynchronous active-high reset
//               btn_raw - asynchronous button levels, 1 = pressed
//               stable  - debounced button vector
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int W               = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn_raw,
    output logic [W-1:0] stable
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [W-1:0]       r_sync1;
    logic [W-1:0]       r_btn_sync;
    logic [W-1:0]       r_cand;
    logic [W-1:0]       r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_btn_sync <= r_sync1;
        end
    end

    // Any difference from the candidate restarts the count; once the count
    // saturates it holds there so a long-stable vector keeps being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (r_btn_sync != r_cand) begin
            r_cand <= r_btn_sync;
            r_cnt  <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/note_input_encoder.sv
`default_nettype none
// ============================================================================
// Module      : note_input_encoder
// Description : Player-side button front end for the note memory game.
//               Debounces the note keys, encodes a single held key into a
//               note code and emits at most one answer strobe per press.
// Ports       : clk           - system clock
//               reset         - asynchronous active-high reset
//               btn_raw       - asynchronous button levels, 1 = pressed
//               arm           - player turn enable; strobes only while high
//               answer        - note code of last accepted press (holds)
//               answer_enable - one-cycle strobe, answer valid same cycle
//               key_code      - code of currently held key, 0 if none/chord
//               chord_err     - one-cycle pulse on a multi-key press
// Revision    : 1.0 - initial release
// ============================================================================
module note_input_encoder
    import note_input_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] btn_raw,
    input  logic                arm,
    output logic [CODE_W-1:0]   answer,
    output logic                answer_enable,
    output logic [CODE_W-1:0]   key_code,
    output logic                chord_err
);

    localparam logic [NUM_KEYS-1:0] c_one = NUM_KEYS'(1);

    logic [NUM_KEYS-1:0] w_stable;
    logic                w_any;
    logic                w_one_hot;
    logic                w_multi;
    logic [CODE_W-1:0]   w_code;

    key_state_t          r_state;
    key_state_t          w_state_next;

    logic [CODE_W-1:0]   r_answer;
    logic                r_answer_enable;
    logic [CODE_W-1:0]   r_key_code;
    logic                r_chord_err;

    logic [CODE_W-1:0]   w_answer_nxt;
    logic                w_answer_enable_nxt;
    logic [CODE_W-1:0]   w_key_code_nxt;
    logic                w_chord_err_nxt;

    key_debouncer #(
        .W               (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .stable  (w_stable)
    );

    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    assign w_any     = (w_stable != '0);
    assign w_one_hot = w_any && ((w_stable & (w_stable - c_one)) == '0);
    assign w_multi   = w_any && !w_one_hot;

    // Only meaningful when the vector is one-hot.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_stable[i]) begin
                w_code = key_to_code(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_one_hot) begin
                    w_state_next = HELD;
                end else if (w_multi) begin
                    w_state_next = CHORD;
                end
            end
            HELD: begin
                // The held key's code is in r_key_code; anything else nonzero
                // (added key or a slide to a different key) is a chord.
                if (!w_any) begin
                    w_state_next = IDLE;
                end else if (!w_one_hot || (w_code != r_key_code)) begin
                    w_state_next = CHORD;
                end
            end
            CHORD: begin
                if (!w_any) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A strobe can only come from the IDLE->HELD edge, so a key already held
    // when arm rises never produces a late strobe.
    always_comb begin
        w_answer_enable_nxt = (r_state == IDLE) && (w_state_next == HELD) && arm;
        w_answer_nxt        = w_answer_enable_nxt ? w_code : r_answer;
        w_key_code_nxt      = (w_state_next == HELD) ? w_code : '0;
        w_chord_err_nxt     = (w_state_next == CHORD) && (r_state != CHORD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_answer        <= '0;
            r_answer_enable <= 1'b0;
            r_key_code      <= '0;
            r_chord_err     <= 1'b0;
        end else begin
            r_answer        <= w_answer_nxt;
            r_answer_enable <= w_answer_enable_nxt;
            r_key_code      <= w_key_code_nxt;
            r_chord_err     <= w_chord_err_nxt;
        end
    end

    assign answer        = r_answer;
    assign answer_enable = r_answer_enable;
    assign key_code      = r_key_code;
    assign chord_err     = r_chord_err;

endmodule
`default_nettype wire

// File: tb/tb_note_input_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_input_encoder
// Description : Self-checking bench for note_input_encoder. A behavioural
//               model (window-based debounce, key-event tracker) predicts
//               every output each cycle; directed scenarios additionally
//               check strobe and chord counts against fixed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_input_encoder;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic         arm;
    logic [3:0]   answer;
    logic         answer_enable;
    logic [3:0]   key_code;
    logic         chord_err;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_chord = 0;
    logic [3:0] last_ans = '0;

    note_input_encoder #(
        .NUM_KEYS        (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .arm           (arm),
        .answer        (answer),
        .answer_enable (answer_enable),
        .key_code      (key_code),
        .chord_err     (chord_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Raw levels reach the debounce two edges late; a
    // vector becomes stable once D+1 consecutive synchronized samples agree.
    // The key tracker remembers which single key is held (-1 none, -2 chord).
    // ------------------------------------------------------------------
    logic [N-1:0] m_s1, m_s2, m_stable;
    logic [N-1:0] hist[$];
    int           m_held;
    logic [3:0]   m_answer, m_key;
    logic         m_en, m_chord;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; hist.delete();
            m_held = -1; m_answer = '0; m_key = '0; m_en = 1'b0; m_chord = 1'b0;
        end else begin
            int ones;
            int idx;
            bit same;
            ones = $countones(m_stable);
            idx  = 0;
            for (int i = 0; i < N; i++) if (m_stable[i]) idx = i;
            m_en = 1'b0;
            m_chord = 1'b0;
            if (m_held == -1) begin
                if (ones == 1) begin
                    m_held = idx;
                    m_key  = 4'(idx + 1);
                    if (arm) begin
                        m_en = 1'b1;
                        m_answer = 4'(idx + 1);
                    end
                end else if (ones > 1) begin
                    m_held = -2;
                    m_chord = 1'b1;
                end
            end else if (m_held >= 0) begin
                if (ones == 0) begin
                    m_held = -1;
                    m_key = '0;
                end else if (!(ones == 1 && idx == m_held)) begin
                    m_held = -2;
                    m_key = '0;
                    m_chord = 1'b1;
                end
            end else if (ones == 0) begin
                m_held = -1;
            end
            hist.push_back(m_s2);
            if (hist.size() > D + 1) void'(hist.pop_front());
            if (hist.size() == D + 1) begin
                same = 1'b1;
                foreach (hist[j]) if (hist[j] != hist[0]) same = 1'b0;
                if (same) m_stable = hist[0];
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    always @(negedge clk) begin
        check_eq("answer_enable", 8'(answer_enable), 8'(m_en));
        check_eq("chord_err", 8'(chord_err), 8'(m_chord));
        check_eq("key_code", 8'(key_code), 8'(m_key));
        check_eq("answer", 8'(answer), 8'(m_answer));
        if (answer_enable) begin
            n_strobe++;
            last_ans = answer;
        end
        if (chord_err) n_chord++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic scen_check(input string tag, input int exp_strobes, input int exp_ans, input int exp_chords);
        check_eq({tag, "_strobes"}, 8'(n_strobe), 8'(exp_strobes));
        if (exp_strobes > 0) check_eq({tag, "_answer"}, 8'(last_ans), 8'(exp_ans));
        check_eq({tag, "_chords"}, 8'(n_chord), 8'(exp_chords));
        n_strobe = 0;
        n_chord = 0;
    endtask

    initial begin
        int t;
        int len;
        int r;
        reset = 1'b1; arm = 1'b0; btn_raw = '0;
        cyc(3);
        check_eq("rst_answer", 8'(answer), 8'd0);
        check_eq("rst_enable", 8'(answer_enable), 8'd0);
        check_eq("rst_key_code", 8'(key_code), 8'd0);
        check_eq("rst_chord", 8'(chord_err), 8'd0);
        reset = 1'b0;
        cyc(8);
        n_strobe = 0; n_chord = 0;

        // Single press of key 2
        arm = 1'b1; btn_raw = 8'h04;
        cyc(20);
        check_eq("single_key_code", 8'(key_code), 8'd3);
        btn_raw = '0;
        cyc(12);
        check_eq("single_release", 8'(key_code), 8'd0);
        scen_check("single", 1, 3, 0);

        // Bouncing key 5
        t = 0;
        while (t < 30) begin
            len = $urandom_range(1, 3);
            btn_raw = btn_raw ^ 8'h20;
            cyc(len);
            t += len;
        end
        btn_raw = 8'h20;
        cyc(12);
        btn_raw = '0;
        cyc(12);
        scen_check("bounce", 1, 6, 0);

        // Chord of keys 0 and 1, partial release, then a clean press of key 1
        btn_raw = 8'h03; cyc(12);
        btn_raw = 8'h02; cyc(12);
        btn_raw = 8'h00; cyc(12);
        scen_check("chord", 0, 0, 1);
        btn_raw = 8'h02; cyc(12);
        btn_raw = 8'h00; cyc(12);
        scen_check("after_chord", 1, 2, 0);

        // Disarmed press of key 7, arm raised while held, then re-press
        arm = 1'b0; btn_raw = 8'h80; cyc(12);
        check_eq("disarm_key_code", 8'(key_code), 8'd8);
        arm = 1'b1; cyc(5);
        btn_raw = 8'h00; cyc(12);
        scen_check("disarmed", 0, 0, 0);
        btn_raw = 8'h80; cyc(12);
        btn_raw = 8'h00; cyc(12);
        scen_check("rearmed", 1, 8, 0);

        // Reset while key 3 is held
        btn_raw = 8'h08; cyc(12);
        check_eq("hold_key_code", 8'(key_code), 8'd4);
        n_strobe = 0;
        reset = 1'b1;
        #1;
        check_eq("midrst_key_code", 8'(key_code), 8'd0);
        check_eq("midrst_answer", 8'(answer), 8'd0);
        cyc(2);
        reset = 1'b0;
        cyc(12);
        btn_raw = 8'h00; cyc(12);
        scen_check("reset_hold", 1, 4, 0);

        // Slide from key 2 to keys 2+4
        btn_raw = 8'h04; cyc(12);
        btn_raw = 8'h14; cyc(12);
        check_eq("slide_key_code", 8'(key_code), 8'd0);
        btn_raw = 8'h00; cyc(12);
        scen_check("slide", 1, 3, 1);

        // Random traffic against the model
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      btn_raw = 8'(1 << $urandom_range(0, N - 1));
            else if (r <= 6) btn_raw = '0;
            else if (r == 7) btn_raw = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
            else             btn_raw = 8'($urandom_range(0, 255));
            arm = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; cyc(1); reset = 1'b0;
            end
            cyc($urandom_range(1, 10));
        end
        btn_raw = '0;
        cyc(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_input_encoder.md
# note_input_encoder

Player-side front end for the note memory game. It takes the raw push-button vector for the note keys and produces the one-cycle `answer_enable` strobe and 4-bit `answer` code that the game controller consumes. Each button is synchronized and debounced, the one-hot press is encoded, and at most one strobe is emitted per physical press. The block sits between the board buttons and the game controller, alongside the piezo/LED echo path.

## Interface
- `NUM_KEYS`, default 8: number of note buttons; legal range 1..15.
- `DEBOUNCE_CYCLES`, default 250000: stable-cycle count required to accept a change (5 ms at 50 MHz); minimum 2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  NUM_KEYS  asynchronous button levels, 1 = pressed.
- `arm`  in  1  player turn enable (`my_turn`); strobes are produced only while high.
- `answer`  out  4  note code of the last accepted press, key i maps to code i+1; holds between presses.
- `answer_enable`  out  1  one-cycle strobe; `answer` is valid in the same cycle.
- `key_code`  out  4  code of the currently held key for LED/piezo echo; 0 when none is held or in a chord.
- `chord_err`  out  1  one-cycle pulse when more than one key is accepted simultaneously.

## Operation
- Synchronizer: two flops per bit, producing `btn_sync`.
- Shared vector debounce, with registers `cand` and `cnt`:
  - If `btn_sync != cand`: `cand <= btn_sync`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, and `cnt` holds.
  - Else `cnt++`.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES)`. `cnt` never wraps.
- FSM states are IDLE, HELD, and CHORD. It evaluates `stable` every cycle.
  - IDLE, `stable == 0`: stay.
  - IDLE, `stable` one-hot with bit i set: go to HELD. `key_code <= i+1`. If `arm` is high, `answer <= i+1` and pulse `answer_enable`. If `arm` is low, emit nothing; the press is consumed.
  - IDLE, `stable` has two or more bits set: go to CHORD and pulse `chord_err`.
  - HELD, `stable == 0`: go to IDLE and set `key_code <= 0`.
  - HELD, `stable` changes to any other nonzero value: go to CHORD, pulse `chord_err`, set `key_code <= 0`. No new strobe.
  - CHORD: stay until `stable == 0`, then go to IDLE. No strobe is ever emitted from CHORD.
- Exactly one strobe is allowed per IDLE→HELD transition. A key held across an `arm` rising edge never strobes late.
- `arm` falling while in HELD has no effect on state.

## Timing
- All outputs reset to 0. State resets to IDLE. Synchronizers, `cand`, `cnt`, and `stable` reset to 0.
- Latency: `btn_raw` changes before edge k and then stays constant. `stable` updates at edge k+2+`DEBOUNCE_CYCLES`. `answer_enable`, `answer`, and `key_code` update at edge k+3+`DEBOUNCE_CYCLES`.
- `answer_enable` and `chord_err` are high for exactly one cycle and are never high together.
- Glitch filtering: any `btn_sync` change lasting fewer than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged. It does restart `cnt`.
- Release uses the same debounce, so release latency equals press latency.
- Reset mid-press: all state clears immediately. A button still held after reset deasserts is treated as a new press and strobes after the full latency, provided `arm` is high.
- No back-pressure: the consumer must accept `answer_enable` in its strobe cycle.

## Structure
- Package `note_input_pkg` holds:
  - the FSM state enum (IDLE/HELD/CHORD);
  - `CODE_W = 4`;
  - `MAX_KEYS = 15`;
  - the key-index-to-code function (index+1).
- Sub-module `key_debouncer` (parameters `W`, `DEBOUNCE_CYCLES`) contains the synchronizer and the shared vector debounce, and outputs `stable[W-1:0]`.
- The top level contains the FSM, the one-hot check, the encoder, and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and `NUM_KEYS = 8`.
- Single press: `arm=1`, press key 2 before edge k, hold 20 cycles, release. Expect `answer=3` and `answer_enable` high only in the cycle after edge k+7, `key_code=3` until release latency expires, then 0. No second strobe.
- Bounce: key 5 toggles with 1–3 cycle pulses for 30 cycles, then holds steady. Expect exactly one strobe with `answer=6`, 7 cycles after the last toggle.
- Chord: keys 0 and 1 pressed together → one `chord_err` pulse and no strobe. Release key 0 while key 1 stays held → still no strobe. Release all, then press key 1 → strobe with `answer=2`.
- Disarmed: `arm=0`, press key 7 → no strobe and `key_code=8`. Raise `arm` while the key is held → no strobe. Release, then press again → strobe with `answer=8`.
- Reset mid-hold: key 3 held with state HELD; assert `reset` for 2 cycles while the key stays held. Expect all outputs 0 immediately. After `reset` falls, expect one strobe with `answer=4` after 7 cycles.
- Key slide: key 2 held, then key 4 added → `chord_err` pulse, `key_code=0`, no strobe. Releasing both returns to IDLE.
